sc_datapath: RTL and testbench
==============================

# sc_datapath

Datapath responder for the SC_STATEMACHINE control unit: it executes the decoder, mux, ALU and shift-register commands that the state machine issues each cycle, and returns ALU status flags to it. It holds four general registers (GEN0–GEN3), two constant fixed registers (FIX0, FIX1), two read buses (BUSA, BUSB), an ALU, and a shift register whose output drives the write-back bus BUSC. It sits beside the state machine in the Fibonacci top level, which wires their ports one-to-one.

## Interface
- DATAWIDTH_BUS, 8, width of registers, buses and ALU
- DATAWIDTH_DECODER_SELECTION, 3, clear/load decoder select width
- DATAWIDTH_MUX_SELECTION, 3, BUSA/BUSB select width
- DATAWIDTH_ALU_SELECTION, 4, ALU opcode width
- DATAWIDTH_REGSHIFTER_SELECTION, 2, shift select width
- FIX0_VALUE, 8'h01, constant driven by FIX0
- FIX1_VALUE, 8'h01, constant driven by FIX1

Ports:
- SC_STATEMACHINE_CLOCK_50  in  1  system clock; all state updates on its rising edge
- SC_STATEMACHINE_RESET_InHigh  in  1  reset, asynchronous, active-high
- decoderclearselection_InBUS  in  3  000–011 clear GENn; other codes select none
- decoderloadselection_InBUS  in  3  000–011 load GENn from BUSC; other codes select none
- muxselectionBUSA_InBUS  in  3  000–011 GENn, 100 FIX0, 101 FIX1, 110/111 drive 0
- muxselectionBUSB_InBUS  in  3  same encoding as BUSA
- aluselection_InBUS  in  4  ALU opcode
- regSHIFTERclear_InLow  in  1  0 clears the shift register
- regSHIFTERload_InLow  in  1  0 loads the ALU result into the shift register
- regSHIFTERshiftselection_InLow  in  2  01 shift left, 10 shift right, 00/11 hold
- overflow_OutLow, carry_OutLow, negative_OutLow, zero_OutLow  out  1 each  registered flags; 0 means the flag is set
- busc_Out  out  8  shift-register contents (BUSC)
- gen3_Out  out  8  GEN3 contents, for display

## Operation
- ALU, combinational on BUSA (A) and BUSB (B):
  - 0000 A; 0001 A|B; 0010 A&B; 0011 ~A; 0100 A^B; 0101–0111 A.
  - 1000 A+B; 1001 A−B; 1010 A+1; 1011 A−1; 1100–1111 A.
- Arithmetic is done at width+1. Result is truncated to DATAWIDTH_BUS.
- Carry: carry-out for ADD/INC; borrow (A<B unsigned, or A==0 for DEC) for SUB/DEC.
- Overflow is two's-complement signed overflow.
- Logic and pass opcodes force carry=0 and overflow=0.
- negative = result MSB; zero = (result == 0).
- Shift register priority per edge:
  - clear (0) wins over load (0), which wins over shift, which wins over hold.
  - Left shift inserts 0 at the LSB. Right shift is logical and inserts 0 at the MSB. The bit shifted out is discarded.
- Flags are captured only on a load edge, from the ALU result being loaded.
  - A clear edge forces all flags inactive (1).
  - Otherwise flags hold.
- Register file: on each edge, GEN[clear sel] ← 0, and GEN[load sel] ← BUSC (the value before that edge).
  - If both selects name the same register, clear wins.
  - Different registers update in parallel.
- FIX0/FIX1 are constants and are never writable.

## Timing
- Reset (asynchronous, active-high): GEN0–GEN3 = 0, shift register = 0, busc_Out = 0, gen3_Out = 0, all flag outputs = 1. Reset mid-operation aborts it immediately; no partial write survives.
- The three-state ADD sequence (ops, then shift load, then decoder load) takes 3 cycles:
  - Cycle 0: ALU operands and opcode settle.
  - Edge at end of cycle 1: ALU result and flags are latched into the shift register and flag registers.
  - Edge at end of cycle 2: BUSC is written into GEN.
- gen3_Out updates on the edge that loads GEN3.
- busc_Out and the flags update on the shift-register edge. Flags are valid for the state machine one cycle after the load state.
- No handshake: every command is acted on at the next edge.

## Structure
- Package sc_datapath_pkg holds:
  - ALU opcodes (ALU_PASS, ALU_OR, … ALU_DEC).
  - Mux codes (SEL_GEN0–SEL_GEN3, SEL_FIX0, SEL_FIX1).
  - Decoder code DEC_NONE = 3'b111.
  - Shift codes (SHIFT_LEFT = 01, SHIFT_RIGHT = 10).
- One sub-module: sc_alu (purely combinational; result plus four flags). The top module holds the register file, bus muxes, shift register and flag registers.

## Test plan
- Reset: pulse reset mid-clock → immediately GEN0–GEN3 = 0, busc_Out = 0, all four flag outputs = 1.
- ADD FIX0+FIX1 (defaults): BUSA = 100, BUSB = 101, ALU = 1000 for 1 cycle; then load = 0; then decoder load = 011 → gen3_Out = 8'h02, all flags 1.
- Carry/zero: FIX0_VALUE = 8'hFF, FIX1_VALUE = 8'h01, ADD → busc_Out = 8'h00, carry_OutLow = 0, zero_OutLow = 0, overflow_OutLow = 1. With FIX0_VALUE = 8'h7F → 8'h80, overflow_OutLow = 0, negative_OutLow = 0, carry_OutLow = 1.
- Shift: FIX0_VALUE = 8'h81, ALU pass, load → busc_Out = 8'h81. Shift 01 → 8'h02. Shift 10 → 8'h01. Code 11 for 3 cycles → 8'h01 held.
- Priority:
  - Clear select = load select = 010 in the same cycle with BUSC = 8'h05 → GEN2 = 0.
  - Shifter clear = 0 and load = 0 together → busc_Out = 0, flags all 1.
- Reset during load cycle: assert reset while load = 0 → shift register, flags and GEN3 stay at reset values after release until a new sequence runs.

Source files
------------

// File: rtl/sc_datapath_pkg.sv
// Shared codes for the SC_STATEMACHINE datapath: ALU opcodes, bus mux selects,
// decoder and shift-register command encodings.
package sc_datapath_pkg;

    localparam int NUM_GEN = 4;

    typedef enum logic [3:0] {
        ALU_PASS = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_NOT  = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_ADD  = 4'b1000,
        ALU_SUB  = 4'b1001,
        ALU_INC  = 4'b1010,
        ALU_DEC  = 4'b1011
    } alu_op_t;

    localparam logic [2:0] SEL_GEN0 = 3'b000;
    localparam logic [2:0] SEL_GEN1 = 3'b001;
    localparam logic [2:0] SEL_GEN2 = 3'b010;
    localparam logic [2:0] SEL_GEN3 = 3'b011;
    localparam logic [2:0] SEL_FIX0 = 3'b100;
    localparam logic [2:0] SEL_FIX1 = 3'b101;

    localparam logic [2:0] DEC_NONE = 3'b111;

    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;

endpackage

// File: rtl/sc_datapath_alu.sv
// Combinational ALU: logic ops, pass-through and width+1 arithmetic with
// active-high carry/borrow, signed overflow, negative and zero status.
module sc_alu
    import sc_datapath_pkg::*;
#(
    parameter int DATAWIDTH_BUS           = 8,
    parameter int DATAWIDTH_ALU_SELECTION = 4
) (
    input  logic [DATAWIDTH_BUS-1:0]           i_a,
    input  logic [DATAWIDTH_BUS-1:0]           i_b,
    input  logic [DATAWIDTH_ALU_SELECTION-1:0] i_op,
    output logic [DATAWIDTH_BUS-1:0]           o_result,
    output logic                               o_carry,
    output logic                               o_overflow,
    output logic                               o_negative,
    output logic                               o_zero
);

    localparam int W = DATAWIDTH_BUS;

    logic [W:0]   w_ext;
    logic [W-1:0] w_result;
    logic         w_carry;
    logic         w_overflow;

    // The extra top bit of w_ext is the carry-out for add/inc and the borrow
    // for sub/dec; logic and pass opcodes leave carry and overflow cleared.
    always_comb begin
        w_ext      = '0;
        w_result   = i_a;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        case (i_op)
            ALU_PASS: w_result = i_a;
            ALU_OR:   w_result = i_a | i_b;
            ALU_AND:  w_result = i_a & i_b;
            ALU_NOT:  w_result = ~i_a;
            ALU_XOR:  w_result = i_a ^ i_b;
            ALU_ADD: begin
                w_ext      = {1'b0, i_a} + {1'b0, i_b};
                w_result   = w_ext[W-1:0];
                w_carry    = w_ext[W];
                w_overflow = (i_a[W-1] == i_b[W-1]) && (w_result[W-1] != i_a[W-1]);
            end
            ALU_SUB: begin
                w_ext      = {1'b0, i_a} - {1'b0, i_b};
                w_result   = w_ext[W-1:0];
                w_carry    = w_ext[W];
                w_overflow = (i_a[W-1] != i_b[W-1]) && (w_result[W-1] != i_a[W-1]);
            end
            ALU_INC: begin
                w_ext      = {1'b0, i_a} + (W+1)'(1);
                w_result   = w_ext[W-1:0];
                w_carry    = w_ext[W];
                w_overflow = ~i_a[W-1] & w_result[W-1];
            end
            ALU_DEC: begin
                w_ext      = {1'b0, i_a} - (W+1)'(1);
                w_result   = w_ext[W-1:0];
                w_carry    = w_ext[W];
                w_overflow = i_a[W-1] & ~w_result[W-1];
            end
            default: w_result = i_a;
        endcase
    end

    assign o_result   = w_result;
    assign o_carry    = w_carry;
    assign o_overflow = w_overflow;
    assign o_negative = w_result[W-1];
    assign o_zero     = (w_result == '0);

endmodule

// File: rtl/sc_datapath.sv
// Datapath beside SC_STATEMACHINE: GEN0-GEN3 register file, FIX constants,
// BUSA/BUSB muxes, ALU, shift register driving BUSC and active-low flags.
module sc_datapath
    import sc_datapath_pkg::*;
#(
    parameter int                 DATAWIDTH_BUS                  = 8,
    parameter int                 DATAWIDTH_DECODER_SELECTION    = 3,
    parameter int                 DATAWIDTH_MUX_SELECTION        = 3,
    parameter int                 DATAWIDTH_ALU_SELECTION        = 4,
    parameter int                 DATAWIDTH_REGSHIFTER_SELECTION = 2,
    parameter logic [DATAWIDTH_BUS-1:0] FIX0_VALUE               = 8'h01,
    parameter logic [DATAWIDTH_BUS-1:0] FIX1_VALUE               = 8'h01
) (
    input  logic                                      SC_STATEMACHINE_CLOCK_50,
    input  logic                                      SC_STATEMACHINE_RESET_InHigh,
    input  logic [DATAWIDTH_DECODER_SELECTION-1:0]    decoderclearselection_InBUS,
    input  logic [DATAWIDTH_DECODER_SELECTION-1:0]    decoderloadselection_InBUS,
    input  logic [DATAWIDTH_MUX_SELECTION-1:0]        muxselectionBUSA_InBUS,
    input  logic [DATAWIDTH_MUX_SELECTION-1:0]        muxselectionBUSB_InBUS,
    input  logic [DATAWIDTH_ALU_SELECTION-1:0]        aluselection_InBUS,
    input  logic                                      regSHIFTERclear_InLow,
    input  logic                                      regSHIFTERload_InLow,
    input  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] regSHIFTERshiftselection_InLow,
    output logic                                      overflow_OutLow,
    output logic                                      carry_OutLow,
    output logic                                      negative_OutLow,
    output logic                                      zero_OutLow,
    output logic [DATAWIDTH_BUS-1:0]                  busc_Out,
    output logic [DATAWIDTH_BUS-1:0]                  gen3_Out
);

    localparam int W = DATAWIDTH_BUS;

    logic [W-1:0] r_gen [NUM_GEN];
    logic [W-1:0] r_shift;
    logic         r_overflowN;
    logic         r_carryN;
    logic         r_negativeN;
    logic         r_zeroN;

    logic [W-1:0] w_busA;
    logic [W-1:0] w_busB;
    logic [W-1:0] w_aluResult;
    logic         w_aluCarry;
    logic         w_aluOverflow;
    logic         w_aluNegative;
    logic         w_aluZero;

    // Unused select codes (110/111) park the bus at zero.
    function automatic logic [W-1:0] muxBus(
        input logic [DATAWIDTH_MUX_SELECTION-1:0] sel,
        input logic [W-1:0] g0,
        input logic [W-1:0] g1,
        input logic [W-1:0] g2,
        input logic [W-1:0] g3
    );
        logic [W-1:0] value;
        value = '0;
        case (sel)
            SEL_GEN0: value = g0;
            SEL_GEN1: value = g1;
            SEL_GEN2: value = g2;
            SEL_GEN3: value = g3;
            SEL_FIX0: value = FIX0_VALUE;
            SEL_FIX1: value = FIX1_VALUE;
            default:  value = '0;
        endcase
        return value;
    endfunction

    always_comb begin
        w_busA = muxBus(muxselectionBUSA_InBUS, r_gen[0], r_gen[1], r_gen[2], r_gen[3]);
        w_busB = muxBus(muxselectionBUSB_InBUS, r_gen[0], r_gen[1], r_gen[2], r_gen[3]);
    end

    sc_alu #(
        .DATAWIDTH_BUS           (DATAWIDTH_BUS),
        .DATAWIDTH_ALU_SELECTION (DATAWIDTH_ALU_SELECTION)
    ) u_alu (
        .i_a        (w_busA),
        .i_b        (w_busB),
        .i_op       (aluselection_InBUS),
        .o_result   (w_aluResult),
        .o_carry    (w_aluCarry),
        .o_overflow (w_aluOverflow),
        .o_negative (w_aluNegative),
        .o_zero     (w_aluZero)
    );

    // Register file writes from the pre-edge BUSC; a clear on the same
    // register as a load takes precedence.
    always_ff @(posedge SC_STATEMACHINE_CLOCK_50 or posedge SC_STATEMACHINE_RESET_InHigh) begin
        if (SC_STATEMACHINE_RESET_InHigh) begin
            for (int i = 0; i < NUM_GEN; i++) begin
                r_gen[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_GEN; i++) begin
                if (decoderclearselection_InBUS == DATAWIDTH_DECODER_SELECTION'(i)) begin
                    r_gen[i] <= '0;
                end else if (decoderloadselection_InBUS == DATAWIDTH_DECODER_SELECTION'(i)) begin
                    r_gen[i] <= r_shift;
                end
            end
        end
    end

    // Shift register and flags: clear beats load beats shift beats hold.
    // Flags follow only clear (inactive) and load (captured from the ALU).
    always_ff @(posedge SC_STATEMACHINE_CLOCK_50 or posedge SC_STATEMACHINE_RESET_InHigh) begin
        if (SC_STATEMACHINE_RESET_InHigh) begin
            r_shift     <= '0;
            r_overflowN <= 1'b1;
            r_carryN    <= 1'b1;
            r_negativeN <= 1'b1;
            r_zeroN     <= 1'b1;
        end else if (!regSHIFTERclear_InLow) begin
            r_shift     <= '0;
            r_overflowN <= 1'b1;
            r_carryN    <= 1'b1;
            r_negativeN <= 1'b1;
            r_zeroN     <= 1'b1;
        end else if (!regSHIFTERload_InLow) begin
            r_shift     <= w_aluResult;
            r_overflowN <= ~w_aluOverflow;
            r_carryN    <= ~w_aluCarry;
            r_negativeN <= ~w_aluNegative;
            r_zeroN     <= ~w_aluZero;
        end else begin
            case (regSHIFTERshiftselection_InLow)
                SHIFT_LEFT:  r_shift <= {r_shift[W-2:0], 1'b0};
                SHIFT_RIGHT: r_shift <= {1'b0, r_shift[W-1:1]};
                default:     r_shift <= r_shift;
            endcase
        end
    end

    assign busc_Out        = r_shift;
    assign gen3_Out        = r_gen[3];
    assign overflow_OutLow = r_overflowN;
    assign carry_OutLow    = r_carryN;
    assign negative_OutLow = r_negativeN;
    assign zero_OutLow     = r_zeroN;

endmodule

// File: tb/tb_sc_datapath.sv
// Directed bench for sc_datapath: four instances differing only in FIX0_VALUE
// share one stimulus stream so carry/overflow/shift cases run side by side.
module tb_sc_datapath;

    localparam logic [7:0] FIXV [4] = '{8'h01, 8'hFF, 8'h7F, 8'h81};

    localparam logic [2:0] MA_G0 = 3'b000, MA_G1 = 3'b001, MA_G2 = 3'b010;
    localparam logic [2:0] MA_F0 = 3'b100, MA_F1 = 3'b101, MA_Z = 3'b110;
    localparam logic [2:0] D_NONE = 3'b111;
    localparam logic [3:0] OP_PASS = 4'b0000, OP_OR = 4'b0001, OP_NOT = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100, OP_RSV = 4'b0101, OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1001, OP_INC = 4'b1010, OP_DEC = 4'b1011;

    logic       clock;
    logic       reset;
    logic [2:0] decClr, decLd, muxA, muxB;
    logic [3:0] aluSel;
    logic       shClr, shLd;
    logic [1:0] shSel;

    logic [3:0] ovfL, carL, negL, zerL;
    logic [7:0] busc [4];
    logic [7:0] gen3 [4];

    int testsRun    = 0;
    int testsFailed = 0;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : gDut
            sc_datapath #(
                .FIX0_VALUE (FIXV[g]),
                .FIX1_VALUE (8'h01)
            ) u_dut (
                .SC_STATEMACHINE_CLOCK_50       (clock),
                .SC_STATEMACHINE_RESET_InHigh   (reset),
                .decoderclearselection_InBUS    (decClr),
                .decoderloadselection_InBUS     (decLd),
                .muxselectionBUSA_InBUS         (muxA),
                .muxselectionBUSB_InBUS         (muxB),
                .aluselection_InBUS             (aluSel),
                .regSHIFTERclear_InLow          (shClr),
                .regSHIFTERload_InLow           (shLd),
                .regSHIFTERshiftselection_InLow (shSel),
                .overflow_OutLow                (ovfL[g]),
                .carry_OutLow                   (carL[g]),
                .negative_OutLow                (negL[g]),
                .zero_OutLow                    (zerL[g]),
                .busc_Out                       (busc[g]),
                .gen3_Out                       (gen3[g])
            );
        end
    endgenerate

    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    // Flag nibbles are checked as {ovf, carry, neg, zero}, all active-low.
    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] flags(input int k);
        return {4'b0, ovfL[k], carL[k], negL[k], zerL[k]};
    endfunction

    task automatic applyStimulus(input logic [2:0] a, input logic [2:0] b, input logic [3:0] op,
                                 input logic [2:0] clr, input logic [2:0] ld,
                                 input logic sClr, input logic sLd, input logic [1:0] sSel);
        muxA = a; muxB = b; aluSel = op;
        decClr = clr; decLd = ld;
        shClr = sClr; shLd = sLd; shSel = sSel;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        applyStimulus(MA_Z, MA_Z, OP_PASS, D_NONE, D_NONE, 1'b1, 1'b1, 2'b00);
    endtask

    task automatic runAlu(input logic [2:0] a, input logic [2:0] b, input logic [3:0] op);
        applyStimulus(a, b, op, D_NONE, D_NONE, 1'b1, 1'b1, 2'b00);
        applyStimulus(a, b, op, D_NONE, D_NONE, 1'b1, 1'b0, 2'b00);
    endtask

    task automatic writeGen(input logic [2:0] clr, input logic [2:0] ld);
        applyStimulus(MA_Z, MA_Z, OP_PASS, clr, ld, 1'b1, 1'b1, 2'b00);
    endtask

    initial begin
        reset  = 1'b0;
        muxA   = MA_Z;  muxB = MA_Z; aluSel = OP_PASS;
        decClr = D_NONE; decLd = D_NONE;
        shClr  = 1'b1;  shLd = 1'b1; shSel = 2'b00;

        #15 reset = 1'b1;
        #1;
        checkOutput("rst_busc", busc[0], 8'h00);
        checkOutput("rst_gen3", gen3[0], 8'h00);
        checkOutput("rst_flags", flags(0), 8'h0F);
        #8 reset = 1'b0;
        idle();

        // ADD FIX0+FIX1 through shift load, then write-back into GEN3
        applyStimulus(MA_F0, MA_F1, OP_ADD, D_NONE, D_NONE, 1'b1, 1'b1, 2'b00);
        checkOutput("add_noload_busc", busc[0], 8'h00);
        applyStimulus(MA_F0, MA_F1, OP_ADD, D_NONE, D_NONE, 1'b1, 1'b0, 2'b00);
        checkOutput("add_busc", busc[0], 8'h02);
        checkOutput("add_gen3_before", gen3[0], 8'h00);
        writeGen(D_NONE, 3'b011);
        checkOutput("add_gen3", gen3[0], 8'h02);
        checkOutput("add_flags", flags(0), 8'h0F);
        checkOutput("addFF_busc", busc[1], 8'h00);
        checkOutput("addFF_flags", flags(1), 8'h0A);
        checkOutput("add7F_busc", busc[2], 8'h80);
        checkOutput("add7F_flags", flags(2), 8'h05);
        checkOutput("add7F_gen3", gen3[2], 8'h80);

        // Shift register on FIX0 = 81
        runAlu(MA_F0, MA_Z, OP_PASS);
        checkOutput("sh_load", busc[3], 8'h81);
        checkOutput("sh_load_flags", flags(3), 8'h0D);
        applyStimulus(MA_Z, MA_Z, OP_PASS, D_NONE, D_NONE, 1'b1, 1'b1, 2'b01);
        checkOutput("sh_left", busc[3], 8'h02);
        checkOutput("sh_left_def", busc[0], 8'h02);
        applyStimulus(MA_Z, MA_Z, OP_PASS, D_NONE, D_NONE, 1'b1, 1'b1, 2'b10);
        checkOutput("sh_right", busc[3], 8'h01);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(MA_Z, MA_Z, OP_PASS, D_NONE, D_NONE, 1'b1, 1'b1, 2'b11);
        end
        checkOutput("sh_hold", busc[3], 8'h01);
        checkOutput("sh_hold_flags", flags(3), 8'h0D);

        // ALU opcode coverage
        runAlu(MA_F0, MA_F1, OP_SUB);
        checkOutput("sub_zero", busc[0], 8'h00);
        checkOutput("sub_zero_flags", flags(0), 8'h0E);
        checkOutput("sub81", busc[3], 8'h80);
        checkOutput("sub81_flags", flags(3), 8'h0D);
        runAlu(MA_G0, MA_Z, OP_DEC);
        checkOutput("dec0", busc[0], 8'hFF);
        checkOutput("dec0_flags", flags(0), 8'h09);
        runAlu(MA_Z, MA_F1, OP_SUB);
        checkOutput("sub_borrow", busc[0], 8'hFF);
        checkOutput("sub_borrow_flags", flags(0), 8'h09);
        runAlu(MA_F0, MA_Z, OP_NOT);
        checkOutput("not", busc[0], 8'hFE);
        checkOutput("not_flags", flags(0), 8'h0D);
        runAlu(MA_F0, MA_F1, OP_XOR);
        checkOutput("xor", busc[0], 8'h00);
        checkOutput("xor81", busc[3], 8'h80);
        runAlu(MA_F0, MA_F1, OP_OR);
        checkOutput("or81", busc[3], 8'h81);
        runAlu(MA_F0, MA_Z, OP_INC);
        checkOutput("incFF", busc[1], 8'h00);
        checkOutput("incFF_flags", flags(1), 8'h0A);
        checkOutput("inc7F_flags", flags(2), 8'h05);
        runAlu(MA_F0, MA_F1, OP_RSV);
        checkOutput("rsv_pass", busc[3], 8'h81);
        checkOutput("rsv_flags", flags(3), 8'h0D);

        // Register file: build 05, then clear/load conflict on GEN2
        runAlu(MA_F0, MA_Z, OP_INC);
        writeGen(D_NONE, MA_G0);
        runAlu(MA_G0, MA_G0, OP_ADD);
        writeGen(D_NONE, MA_G1);
        runAlu(MA_G1, MA_Z, OP_INC);
        checkOutput("build05", busc[0], 8'h05);
        writeGen(D_NONE, MA_G2);
        writeGen(MA_G2, MA_G2);
        writeGen(MA_G0, 3'b011);
        checkOutput("par_gen3", gen3[0], 8'h05);
        runAlu(MA_G2, MA_Z, OP_PASS);
        checkOutput("clr_wins_gen2", busc[0], 8'h00);
        checkOutput("clr_wins_zero", flags(0), 8'h0E);
        runAlu(MA_G0, MA_Z, OP_PASS);
        checkOutput("par_gen0_clr", busc[0], 8'h00);
        runAlu(MA_G1, MA_Z, OP_PASS);
        checkOutput("gen1_kept", busc[0], 8'h04);

        // Shifter clear beats load
        runAlu(MA_G0, MA_Z, OP_DEC);
        checkOutput("pre_clr_flags", flags(0), 8'h09);
        applyStimulus(MA_G0, MA_Z, OP_DEC, D_NONE, D_NONE, 1'b0, 1'b0, 2'b00);
        checkOutput("shclr_busc", busc[0], 8'h00);
        checkOutput("shclr_flags", flags(0), 8'h0F);

        // Reset asserted during the load cycle
        runAlu(MA_F0, MA_Z, OP_DEC);
        checkOutput("pre_rst_busc", busc[1], 8'hFE);
        applyStimulus(MA_F0, MA_F1, OP_ADD, D_NONE, D_NONE, 1'b1, 1'b1, 2'b00);
        shLd = 1'b0;
        #4 reset = 1'b1;
        #1;
        checkOutput("rstld_busc_now", busc[1], 8'h00);
        checkOutput("rstld_gen3_now", gen3[0], 8'h00);
        checkOutput("rstld_flags_now", flags(1), 8'h0F);
        @(posedge clock);
        #1;
        muxA = MA_Z; muxB = MA_Z; aluSel = OP_PASS; shLd = 1'b1;
        #5 reset = 1'b0;
        idle();
        idle();
        checkOutput("rstld_busc", busc[0], 8'h00);
        checkOutput("rstld_busc1", busc[1], 8'h00);
        checkOutput("rstld_gen3", gen3[0], 8'h00);
        checkOutput("rstld_flags", flags(1), 8'h0F);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
